// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
//   lsu_mem_w_type_t : access width/sign encoding carried on req_type
//   lsu_state_t      : LSU sequencer states
//   lsu_req_t        : request fields captured at accept
package lsu_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH   = 11;
    localparam int unsigned SRAM_READ_LATENCY = 2;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned LSU_TYPE_W        = 3;

    typedef enum logic [LSU_TYPE_W-1:0] {
        WORD   = 3'd0,
        HWORD  = 3'd1,
        HWORDU = 3'd2,
        BYTE   = 3'd3,
        BYTEU  = 3'd4
    } lsu_mem_w_type_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        MERGE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    typedef struct packed {
        logic                  write;
        logic [LSU_TYPE_W-1:0] mtype;
        logic [1:0]            offset;
        logic [DATA_W-1:0]     wdata;
    } lsu_req_t;

    // Illegal encoding or an offset that the access width cannot reach.
    function automatic logic lsu_req_err(input logic [LSU_TYPE_W-1:0] t,
                                         input logic [1:0]            off);
        logic err;
        err = 1'b0;
        if (t > LSU_TYPE_W'(BYTEU))                      err = 1'b1;
        else if (t == WORD && off != 2'd0)               err = 1'b1;
        else if ((t == HWORD || t == HWORDU) && off[0])  err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response bus of the LSU.
//   master : execute stage (drives req_*, receives resp_* and req_ready)
//   slave  : LSU
// req_type is a raw 3-bit field so that undefined encodings can reach the
// LSU and be reported as errors.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [LSU_TYPE_W-1:0] req_type;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_W-1:0]     resp_rdata;

    modport master (
        output req_valid, req_write, req_type, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_type, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Sub-word lane handling, purely combinational.
//   word         : word read from SRAM
//   offset       : byte offset within the word
//   mtype        : access width/sign
//   wdata        : right-aligned store data
//   load_data_c  : extracted and extended load result
//   merge_data_c : word with the addressed byte/halfword replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0]     word,
    input  logic [1:0]            offset,
    input  logic [LSU_TYPE_W-1:0] mtype,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     load_data_c,
    output logic [DATA_W-1:0]     merge_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = word[{offset[1], 4'b0000} +: 16];

    // Load extraction
    always_comb begin
        load_data_c = word;
        case (mtype)
            HWORD:   load_data_c = {{16{half_lane[15]}}, half_lane};
            HWORDU:  load_data_c = {16'h0000, half_lane};
            BYTE:    load_data_c = {{24{byte_lane[7]}}, byte_lane};
            BYTEU:   load_data_c = {24'h000000, byte_lane};
            default: load_data_c = word;
        endcase
    end

    // Store merge; unsigned variants behave as their signed counterparts
    always_comb begin
        merge_data_c = word;
        case (mtype)
            HWORD, HWORDU: merge_data_c[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            BYTE, BYTEU:   merge_data_c[{offset, 3'b000} +: 8]      = wdata[7:0];
            default:       merge_data_c = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a single-port, whole-word data SRAM.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : lsu_if.slave request/response handshake
//   sram_*    : SRAM strobe, write strobe, word address, write/read data
// One request in flight. Sub-word stores are done as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned SRAM_ADDR_W  = SRAM_ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = SRAM_READ_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    lsu_if.slave                   bus,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_din,
    input  logic [DATA_W-1:0]      sram_dout
);

    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    lsu_state_t             state, state_d;
    logic [LAT_W-1:0]       lat_cnt, lat_cnt_d;
    lsu_req_t               req_q, req_d;

    logic                   ready_d, resp_valid_d, resp_err_d;
    logic [DATA_W-1:0]      resp_rdata_d;
    logic                   sram_en_d, sram_we_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_d;
    logic [DATA_W-1:0]      sram_din_d;

    logic [DATA_W-1:0]      load_data_c, merge_data_c;
    logic                   accept_c, word_store_c;

    // Upper address bits alias onto the SRAM and are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:SRAM_ADDR_W+2]};

    assign accept_c     = bus.req_valid && bus.req_ready;
    assign word_store_c = req_q.write && (req_q.mtype == WORD);

    lsu_align u_align (
        .word         (sram_dout),
        .offset       (req_q.offset),
        .mtype        (req_q.mtype),
        .wdata        (req_q.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            req_q          <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            sram_en        <= 1'b0;
            sram_we        <= 1'b0;
            sram_addr      <= '0;
            sram_din       <= '0;
        end else begin
            state          <= state_d;
            lat_cnt        <= lat_cnt_d;
            req_q          <= req_d;
            bus.req_ready  <= ready_d;
            bus.resp_valid <= resp_valid_d;
            bus.resp_err   <= resp_err_d;
            bus.resp_rdata <= resp_rdata_d;
            sram_en        <= sram_en_d;
            sram_we        <= sram_we_d;
            sram_addr      <= sram_addr_d;
            sram_din       <= sram_din_d;
        end
    end

    // Next state; output registers are loaded with the value for the state being entered
    always_comb begin
        state_d      = state;
        lat_cnt_d    = lat_cnt;
        req_d        = req_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr;
        sram_din_d   = sram_din;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    req_d.write  = bus.req_write;
                    req_d.mtype  = bus.req_type;
                    req_d.offset = bus.req_addr[1:0];
                    req_d.wdata  = bus.req_wdata;
                    if (lsu_req_err(bus.req_type, bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        sram_en_d   = 1'b1;
                        sram_we_d   = bus.req_write && (bus.req_type == WORD);
                        sram_addr_d = bus.req_addr[SRAM_ADDR_W+1:2];
                        sram_din_d  = bus.req_wdata;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ISSUE: begin
                if (word_store_c) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (req_q.write) begin
                        state_d    = MERGE;
                        sram_en_d  = 1'b1;
                        sram_we_d  = 1'b1;
                        sram_din_d = merge_data_c;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data_c;
                    end
                end else begin
                    lat_cnt_d = lat_cnt - LAT_W'(1);
                end
            end
            MERGE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
